// File: rtl/ami_pkg.sv
// ami_pkg: shared FSM state type and byte-strobe mask helper for the AXI write-beat path.
package ami_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int MAX_BYTES = 256;
  // Strobe mask for a beat: lanes from off upward on the first beat, lanes up to eoff on the last beat.
  function automatic logic [MAX_BYTES-1:0] strb_mask(input logic [7:0] off, input logic [7:0] eoff,
                                                     input logic first, input logic last);
    logic [MAX_BYTES-1:0] ones;
    ones = '1;
    strb_mask = (first ? ones << off : ones) & (last ? ~((ones << eoff) << 1) : ones);
  endfunction
endpackage

// File: rtl/ami_wstrb_mask.sv
// ami_wstrb_mask: combinational beat strobe and burst-last generation.
module ami_wstrb_mask
  import ami_pkg::*;
#(
  parameter int AXI_BYTES = 16,
  parameter int L = 4,
  parameter int B = 8
) (
  input  logic [L-1:0]         sa_off_i,
  input  logic [L-1:0]         end_off_i,
  input  logic                 first_i,
  input  logic                 last_i,
  input  logic [B-L-1:0]       bidx_i,
  output logic [AXI_BYTES-1:0] wstrb_o,
  output logic                 wlast_o
);
  assign wstrb_o = AXI_BYTES'(strb_mask(8'(sa_off_i), 8'(end_off_i), first_i, last_i));
  assign wlast_o = (&bidx_i) | last_i;
endmodule

// File: rtl/ami_wbeat_gen.sv
// ami_wbeat_gen: splits a byte-addressed write job into strobed AXI write beats
// with burst-boundary wlast and a single registered output stage.
module ami_wbeat_gen
  import ami_pkg::*;
#(
  parameter int AXI_DW = 128,
  parameter int BL = 16,
  localparam int AXI_BYTES = AXI_DW / 8,
  localparam int L = $clog2(AXI_BYTES),
  localparam int B = $clog2(BL) + L
) (
  input  logic                 usr_clk,
  input  logic                 usr_reset_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [31:0]          job_sa,
  input  logic [31:0]          job_len,
  input  logic [AXI_DW-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AXI_DW-1:0]    usr_wdata,
  output logic [AXI_BYTES-1:0] usr_wstrb,
  output logic                 usr_wlast,
  output logic                 usr_wvalid,
  input  logic                 usr_wready,
  output logic                 job_done,
  output logic                 job_err
);
  localparam int AW = 32 - L;
  localparam int CW = 33 - L;
  state_e               state_q;
  logic [L-1:0]         sa_off_q, end_off_q, eoff_d;
  logic [AW-1:0]        waddr_q;
  logic [CW-1:0]        cnt_q, total_q, total_d;
  logic [32:0]          sum_d;
  logic [AXI_DW-1:0]    wdata_q;
  logic [AXI_BYTES-1:0] wstrb_q, wstrb_d;
  logic                 wlast_q, wlast_d, wvalid_q, jlast_q, done_q, err_q;
  logic                 first_d, last_d, in_fire, final_fire;
  // 33-bit sum keeps the beat count exact even for a 4 GiB - 1 job.
  assign sum_d      = 33'(job_sa[L-1:0]) + 33'(job_len) + 33'(AXI_BYTES - 1);
  assign total_d    = CW'(sum_d >> L);
  assign eoff_d     = job_sa[L-1:0] + job_len[L-1:0] - L'(1);
  assign first_d    = cnt_q == '0;
  assign last_d     = cnt_q == total_q - CW'(1);
  assign job_ready  = usr_reset_n & (state_q == IDLE);
  assign in_ready   = usr_reset_n & (state_q == RUN) & (cnt_q < total_q) & (~wvalid_q | usr_wready);
  assign in_fire    = in_valid & in_ready;
  assign final_fire = wvalid_q & usr_wready & jlast_q;
  assign usr_wdata  = wdata_q;
  assign usr_wstrb  = wstrb_q;
  assign usr_wlast  = wlast_q;
  assign usr_wvalid = wvalid_q;
  assign job_done   = done_q;
  assign job_err    = err_q;
  ami_wstrb_mask #(.AXI_BYTES(AXI_BYTES), .L(L), .B(B)) u_mask (
    .sa_off_i (sa_off_q),
    .end_off_i(end_off_q),
    .first_i  (first_d),
    .last_i   (last_d),
    .bidx_i   (waddr_q[B-L-1:0]),
    .wstrb_o  (wstrb_d),
    .wlast_o  (wlast_d)
  );
  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      state_q   <= IDLE;
      sa_off_q  <= '0;
      end_off_q <= '0;
      waddr_q   <= '0;
      cnt_q     <= '0;
      total_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      jlast_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (job_valid) begin
          sa_off_q  <= job_sa[L-1:0];
          end_off_q <= eoff_d;
          waddr_q   <= job_sa[31:L];
          cnt_q     <= '0;
          total_q   <= total_d;
          err_q     <= job_len == '0;
          state_q   <= job_len == '0 ? IDLE : RUN;
        end
      end else begin
        if (in_fire) begin
          wdata_q  <= in_data;
          wstrb_q  <= wstrb_d;
          wlast_q  <= wlast_d;
          jlast_q  <= last_d;
          wvalid_q <= 1'b1;
          cnt_q    <= cnt_q + CW'(1);
          waddr_q  <= waddr_q + AW'(1);
        end else if (usr_wready) begin
          wvalid_q <= 1'b0;
        end
        if (final_fire) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ami_wbeat_gen.sv
// tb_ami_wbeat_gen: directed jobs with a byte-range scoreboard model of strobes and wlast.
module tb_ami_wbeat_gen;
  logic         usr_clk = 1'b0, usr_reset_n = 1'b0, job_valid = 1'b0, in_valid = 1'b0, usr_wready = 1'b1;
  logic [31:0]  job_sa = '0, job_len = '0;
  logic [127:0] in_data = '0;
  logic         job_ready, in_ready, usr_wlast, usr_wvalid, job_done, job_err;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  typedef struct packed {logic [127:0] d; logic [15:0] s; logic l;} beat_t;
  beat_t sb[$];
  int tests = 0, fails = 0;
  always #5 usr_clk = ~usr_clk;
  ami_wbeat_gen #(.AXI_DW(128), .BL(16)) dut (
    .usr_clk(usr_clk), .usr_reset_n(usr_reset_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_sa(job_sa), .job_len(job_len), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wlast(usr_wlast), .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready), .job_done(job_done), .job_err(job_err)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // Byte k of beat i is written iff it falls inside [sa, sa+len) relative to the start word.
  function automatic beat_t exp_beat(input logic [31:0] sa, input logic [31:0] len, input int i, input int n,
                                     input logic [127:0] d);
    beat_t b;
    longint off;
    logic [27:0] w;
    off = longint'(sa[3:0]);
    w = sa[31:4] + 28'(i);
    b.d = d;
    for (int k = 0; k < 16; k++) b.s[k] = (longint'(i * 16 + k) >= off) && (longint'(i * 16 + k) < off + longint'(len));
    b.l = (w[3:0] == 4'hF) || (i == n - 1);
    return b;
  endfunction
  task automatic run_job(input logic [31:0] sa, input logic [31:0] len, input int stall_at, input int stall_n,
                         input int abort_at, input string nm);
    int n, out, inb, cyc, bubbles, stalled;
    logic seen, stall, fire;
    logic [127:0] snap_d;
    logic [15:0] snap_s;
    beat_t e;
    n = int'((longint'(sa[3:0]) + longint'(len) + 15) >> 4);
    out = 0; inb = 0; cyc = 0; bubbles = 0; stalled = 0; seen = 1'b0;
    snap_d = '0; snap_s = '0;
    @(negedge usr_clk);
    chk({nm, " job_ready"}, job_ready, 1);
    job_sa = sa; job_len = len; job_valid = 1'b1;
    @(negedge usr_clk);
    job_valid = 1'b0;
    in_valid = 1'b1; in_data = rnd();
    while (out < n && cyc < 300) begin
      cyc++;
      if (out == abort_at) begin
        usr_reset_n = 1'b0; in_valid = 1'b0;
        @(negedge usr_clk);
        chk({nm, " rst wvalid"}, usr_wvalid, 0);
        chk({nm, " rst wlast"}, usr_wlast, 0);
        chk({nm, " rst wstrb"}, usr_wstrb, 0);
        chk({nm, " rst wdata"}, usr_wdata, 0);
        chk({nm, " rst done"}, job_done, 0);
        chk({nm, " rst err"}, job_err, 0);
        chk({nm, " rst in_ready"}, in_ready, 0);
        chk({nm, " rst job_ready"}, job_ready, 0);
        usr_reset_n = 1'b1;
        @(negedge usr_clk);
        chk({nm, " rel job_ready"}, job_ready, 1);
        chk({nm, " rel done"}, job_done, 0);
        sb.delete();
        return;
      end
      stall = usr_wvalid && out == stall_at && stalled < stall_n;
      usr_wready = !stall;
      #1;
      if (stall) begin
        if (stalled == 0) begin snap_d = usr_wdata; snap_s = usr_wstrb; end
        else begin
          chk({nm, " hold wdata"}, usr_wdata, snap_d);
          chk({nm, " hold wstrb"}, usr_wstrb, snap_s);
        end
        chk({nm, " stall in_ready"}, in_ready, 0);
        stalled++;
      end
      if (usr_wvalid) seen = 1'b1;
      else if (seen) bubbles++;
      if (usr_wvalid && usr_wready) begin
        if (sb.size() == 0) chk({nm, " unexpected beat"}, out, n);
        else begin
          e = sb.pop_front();
          chk($sformatf("%s b%0d wdata", nm, out), usr_wdata, e.d);
          chk($sformatf("%s b%0d wstrb", nm, out), usr_wstrb, e.s);
          chk($sformatf("%s b%0d wlast", nm, out), usr_wlast, e.l);
        end
        out++;
      end
      fire = in_valid && in_ready;
      if (fire) begin sb.push_back(exp_beat(sa, len, inb, n, in_data)); inb++; end
      @(negedge usr_clk);
      if (fire) begin in_data = rnd(); in_valid = inb < n; end
    end
    in_valid = 1'b0; usr_wready = 1'b1;
    chk({nm, " beats out"}, out, n);
    chk({nm, " done pulse"}, job_done, 1);
    chk({nm, " wvalid after"}, usr_wvalid, 0);
    chk({nm, " bubbles"}, bubbles, 0);
    chk({nm, " sb empty"}, sb.size(), 0);
    @(negedge usr_clk);
    chk({nm, " done once"}, job_done, 0);
    chk({nm, " job_ready after"}, job_ready, 1);
  endtask
  initial begin
    #1_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge usr_clk);
    chk("reset wvalid", usr_wvalid, 0);
    chk("reset job_ready", job_ready, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset done", job_done, 0);
    chk("reset err", job_err, 0);
    chk("reset wstrb", usr_wstrb, 0);
    usr_reset_n = 1'b1;
    @(negedge usr_clk);
    chk("release job_ready", job_ready, 1);
    run_job(32'h1000, 32'h100, -1, 0, -1, "b16");
    run_job(32'h1003, 32'd20, -1, 0, -1, "off3");
    run_job(32'h10F0, 32'd32, -1, 0, -1, "bnd");
    run_job(32'h2005, 32'd3, -1, 0, -1, "one");
    @(negedge usr_clk);
    job_sa = 32'h3000; job_len = '0; job_valid = 1'b1;
    @(negedge usr_clk);
    job_valid = 1'b0;
    chk("zero err", job_err, 1);
    chk("zero wvalid", usr_wvalid, 0);
    chk("zero job_ready", job_ready, 1);
    @(negedge usr_clk);
    chk("zero err once", job_err, 0);
    chk("zero no done", job_done, 0);
    chk("zero wvalid2", usr_wvalid, 0);
    run_job(32'h4000, 32'h100, 5, 5, -1, "stall");
    run_job(32'h5000, 32'h100, -1, 0, 7, "abort");
    run_job(32'h6008, 32'd40, -1, 0, -1, "after");
    run_job(32'hFFFF_FFF8, 32'd24, -1, 0, -1, "wrap");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
